// File: rtl/msrv32_reg_block1.sv
// ---------------------------------------------------------------------------
// msrv32_reg_block1
//
// Program-counter register, stage 1 of the MSRV32 (RV32I) pipeline.
// On every rising clock edge it captures the next-PC value chosen by the
// PC-select mux. It presents that value as the current PC to instruction
// fetch and to the stage-2 datapath. The register has no enable and no stall
// input, so the PC advances on every cycle outside reset.
//
// Parameters
//   BOOT_ADDRESS : PC value forced while reset is asserted
//   XLEN         : PC datapath width (only 32 is supported)
//
// Ports
//   clk_in    : system clock, rising edge active
//   rst_in    : asynchronous, active-high reset
//   pc_mux_in : next-PC value from the PC mux
//   pc_out    : registered current PC
// ---------------------------------------------------------------------------
module msrv32_reg_block1 #(
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
   parameter int          XLEN         = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [XLEN-1:0] pc_mux_in,
   output logic [XLEN-1:0] pc_out
);

   // Reset is in the sensitivity list, so the boot address appears as soon
   // as rst_in rises. It is held while rst_in stays high, which also makes
   // clock edges during reset do nothing. The value passes through without
   // any alignment masking; misaligned targets are trapped upstream.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc_out <= BOOT_ADDRESS[XLEN-1:0];
      end else begin
         pc_out <= pc_mux_in;
      end
   end

endmodule

// File: tb/tb_msrv32_reg_block1.sv
// ---------------------------------------------------------------------------
// tb_msrv32_reg_block1
//
// Directed bench for the PC register. It drives two instances from the same
// clock, reset and next-PC inputs: one with the default boot address and one
// with BOOT_ADDRESS = 0x1000. The clock is pulsed by hand so that the bench
// can hold it low, or change the input between edges, exactly when needed.
// Expected values for both instances are pushed to a scoreboard queue when
// the stimulus is applied. They are popped and compared once the DUT output
// has settled.
// ---------------------------------------------------------------------------
module tb_msrv32_reg_block1;

   localparam logic [31:0] BOOT_A = 32'h0000_0000;
   localparam logic [31:0] BOOT_B = 32'h0000_1000;

   typedef struct {
      logic [31:0] expA;
      logic [31:0] expB;
   } expect_t;

   logic        clk;
   logic        rst;
   logic [31:0] pcMux;
   logic [31:0] pcA;
   logic [31:0] pcB;

   expect_t     scoreboard[$];
   int          testsRun;
   int          testsFailed;

   msrv32_reg_block1 #(
      .BOOT_ADDRESS (BOOT_A),
      .XLEN         (32)
   ) dutA (
      .clk_in    (clk),
      .rst_in    (rst),
      .pc_mux_in (pcMux),
      .pc_out    (pcA)
   );

   msrv32_reg_block1 #(
      .BOOT_ADDRESS (BOOT_B),
      .XLEN         (32)
   ) dutB (
      .clk_in    (clk),
      .rst_in    (rst),
      .pc_mux_in (pcMux),
      .pc_out    (pcB)
   );

   // Record what each instance is required to show at the next check.
   task automatic pushExpect(input logic [31:0] a, input logic [31:0] b);
      expect_t e;
      e.expA = a;
      e.expB = b;
      scoreboard.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against both instances.
   task automatic checkOutput(input string tag);
      expect_t e;
      testsRun++;
      assert (scoreboard.size() != 0)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: scoreboard empty, observed a=%h b=%h", tag, pcA, pcB);
      end
      if (scoreboard.size() != 0) begin
         e = scoreboard.pop_front();
         assert (pcA === e.expA)
         else begin
            testsFailed++;
            $error("[TB] FAIL %s/boot0: observed %h expected %h", tag, pcA, e.expA);
         end
         testsRun++;
         assert (pcB === e.expB)
         else begin
            testsFailed++;
            $error("[TB] FAIL %s/boot1000: observed %h expected %h", tag, pcB, e.expB);
         end
      end
   endtask

   // Drive a next-PC value, give one rising edge, and check 1 ns after it.
   // The clock is then returned low. expA and expB are the values the
   // instances must hold after the edge.
   task automatic applyStimulus(input logic [31:0] nextPc,
                                input logic [31:0] expA,
                                input logic [31:0] expB,
                                input string       tag);
      pcMux = nextPc;
      #2;
      pushExpect(expA, expB);
      clk = 1'b1;
      #1;
      checkOutput(tag);
      #4;
      clk = 1'b0;
      #3;
   endtask

   initial begin
      logic [31:0] val;
      logic [31:0] seq [3];

      testsRun    = 0;
      testsFailed = 0;
      clk         = 1'b0;
      rst         = 1'b0;
      pcMux       = 32'h0;

      // Reset with the clock held low: the boot address must appear with no edge.
      #2;
      rst   = 1'b1;
      pcMux = 32'h0;
      #1;
      pushExpect(BOOT_A, BOOT_B);
      checkOutput("reset_async");

      // Clock edges during reset are ignored.
      applyStimulus(32'hFFFF_FFF0, BOOT_A, BOOT_B, "edge_in_reset");

      // After release, the PC must stay at boot until the first edge.
      rst   = 1'b0;
      pcMux = 32'h1234_5678;
      #2;
      pushExpect(BOOT_A, BOOT_B);
      checkOutput("release_no_edge");

      // The first edge after release loads the mux value.
      applyStimulus(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, "first_load");

      // A change between edges must not reach the output, at either clock level.
      pcMux = 32'hDEAD_BEEF;
      #2;
      pushExpect(32'h1234_5678, 32'h1234_5678);
      checkOutput("hold_clk_low");
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #1;
      pcMux = 32'hCAFE_F00D;
      #2;
      pushExpect(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      checkOutput("falling_edge_no_effect");

      // Consecutive edges: the output follows the input with one-edge latency.
      seq[0] = 32'h0000_0004;
      seq[1] = 32'h0000_0008;
      seq[2] = 32'h0000_000C;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(seq[i], seq[i], seq[i], "sequential_pc");
      end

      // Asserting reset mid-cycle gives the boot address at once.
      pcMux = 32'h0000_0010;
      #1;
      rst = 1'b1;
      #1;
      pushExpect(BOOT_A, BOOT_B);
      checkOutput("reset_mid_cycle");

      // The output stays at boot while clocks run under reset.
      for (int i = 0; i < 3; i++) begin
         applyStimulus($urandom, BOOT_A, BOOT_B, "clocks_under_reset");
      end

      // Reset rising together with a clock edge still wins.
      rst = 1'b0;
      applyStimulus(32'h0000_0020, 32'h0000_0020, 32'h0000_0020, "reload_after_reset");
      pcMux = 32'h0000_0024;
      #2;
      clk = 1'b1;
      rst = 1'b1;
      #1;
      pushExpect(BOOT_A, BOOT_B);
      checkOutput("reset_same_edge");
      #4;
      clk = 1'b0;
      #3;

      // Pulse reset and release it. The first edge loads a misaligned value unchanged.
      rst = 1'b0;
      #2;
      pushExpect(BOOT_A, BOOT_B);
      checkOutput("boot_after_pulse");
      applyStimulus(32'h0000_0FFE, 32'h0000_0FFE, 32'h0000_0FFE, "misaligned_load");
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
      applyStimulus(32'h8000_0001, 32'h8000_0001, 32'h8000_0001, "msb_lsb");

      // Random values check that every bit passes through.
      for (int i = 0; i < 8; i++) begin
         val = $urandom;
         applyStimulus(val, val, val, "random_load");
      end

      // Every expectation pushed must have been consumed.
      testsRun++;
      assert (scoreboard.size() == 0)
      else begin
         testsFailed++;
         $error("[TB] FAIL scoreboard_drain: observed %0d left expected 0", scoreboard.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
